// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer
//   Butterfly scheduler for the radix-2 in-place FFT. After start it walks
//   all LOG2N stages. Each stage issues N/2 butterflies (read addresses,
//   twiddle index, read bank). Write-back is the same op delayed by
//   L = 1 + BF_LATENCY cycles, and goes to the opposite bank. A stage's
//   last write must leave the pipe before the next stage's first read.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              begin a transform (sampled only in IDLE)
//   stall              hold off new issues (write pipe keeps moving)
//   busy, done         busy from first issue to last write; done pulse after
//   stage              stage currently issuing/draining
//   rd_en, rd_addr_a/b, tw_idx, rd_bank     butterfly issue
//   wr_en, wr_addr_a/b, wr_bank             delayed write-back
//   result_bank        bank holding the final spectrum
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing butterflies of the current stage
// DRAIN  | waiting for the stage's writes to leave the pipe
// FINISH | done pulse cycle
module fft_bfly_sequencer #(
  parameter int N          = 16,
  parameter int LOG2N      = 4,
  parameter int BF_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_idx,
  output logic                     rd_bank,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic                     wr_bank,
  output logic                     result_bank
);

  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int L  = 1 + BF_LATENCY;
  localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic             bank;
  } wb_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             rd_bank_q, rd_bank_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0]    tw_idx_q, tw_idx_d;
  logic             result_bank_q, result_bank_d;
  wb_t              pipe_q [L];
  wb_t              pipe_d [L];

  logic             drained;
  logic             issue;
  logic [SW-1:0]    iss_stage;
  logic [KW-1:0]    iss_k;
  logic [LOG2N-1:0] k_ext, span, pos, grp, addr_a, addr_b;
  logic [KW-1:0]    tw_val;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    stage_d       = stage_q;
    rd_bank_d     = rd_bank_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rd_en_d       = 1'b0;
    rd_addr_a_d   = rd_addr_a_q;
    rd_addr_b_d   = rd_addr_b_q;
    tw_idx_d      = tw_idx_q;
    result_bank_d = result_bank_q;
    issue         = 1'b0;
    iss_stage     = stage_q;
    iss_k         = k_q;

    // Only the last pipe slot may still hold a write: after this edge the
    // pipe is empty, so the next stage may issue into the cycle that follows
    // the final write.
    drained = !rd_en_q;
    for (int i = 0; i < L - 1; i++) begin
      if (pipe_q[i].v) drained = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          stage_d   = '0;
          k_d       = '0;
          rd_bank_d = 1'b0;
        end
      end
      ISSUE: begin
        if (!stall) begin
          issue = 1'b1;
          if (k_q == K_LAST) state_d = DRAIN;
          else               k_d     = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (drained) begin
          if (stage_q != S_LAST) begin
            // Advance and issue butterfly 0 of the new stage on this same
            // edge, so its rd_en lands right after the last write.
            stage_d   = stage_q + SW'(1);
            iss_stage = stage_d;
            iss_k     = '0;
            rd_bank_d = ~rd_bank_q;
            state_d   = ISSUE;
            k_d       = '0;
            if (!stall) begin
              issue = 1'b1;
              k_d   = KW'(1);
            end
          end else begin
            state_d       = FINISH;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            result_bank_d = ~rd_bank_q;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    k_ext  = {1'b0, iss_k};
    span   = ONE << iss_stage;
    pos    = k_ext & (span - ONE);
    grp    = k_ext >> iss_stage;
    addr_a = ((grp << iss_stage) << 1) | pos;
    addr_b = addr_a | span;
    tw_val = pos[KW-1:0] << (S_LAST - iss_stage);

    if (issue) begin
      rd_en_d     = 1'b1;
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_b;
      tw_idx_d    = tw_val;
      busy_d      = 1'b1;
    end

    pipe_d[0].v    = rd_en_q;
    pipe_d[0].a    = rd_addr_a_q;
    pipe_d[0].b    = rd_addr_b_q;
    pipe_d[0].bank = ~rd_bank_q;
    for (int i = 1; i < L; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      stage_q       <= '0;
      rd_bank_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      tw_idx_q      <= '0;
      result_bank_q <= 1'b0;
      pipe_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      stage_q       <= stage_d;
      rd_bank_q     <= rd_bank_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      tw_idx_q      <= tw_idx_d;
      result_bank_q <= result_bank_d;
      pipe_q        <= pipe_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stage       = stage_q;
  assign rd_en       = rd_en_q;
  assign rd_addr_a   = rd_addr_a_q;
  assign rd_addr_b   = rd_addr_b_q;
  assign tw_idx      = tw_idx_q;
  assign rd_bank     = rd_bank_q;
  assign wr_en       = pipe_q[L-1].v;
  assign wr_addr_a   = pipe_q[L-1].a;
  assign wr_addr_b   = pipe_q[L-1].b;
  assign wr_bank     = pipe_q[L-1].bank;
  assign result_bank = result_bank_q;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Testbench for fft_bfly_sequencer (defaults N=16, LOG2N=4, BF_LATENCY=2).
// Cycle c of a run is the cycle after the c-th rising edge counted from the
// edge that samples start (edge 0).
module tb_fft_bfly_sequencer;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic       busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_idx;

  always #5 clk = ~clk;

  fft_bfly_sequencer #(.N(N), .LOG2N(LOG2N), .BF_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .rd_bank(rd_bank),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_bank(wr_bank), .result_bank(result_bank)
  );

  typedef struct {
    int cyc;
    logic rd_en, wr_en, busy, done;
    logic [1:0] stage;
    logic rd_bank;
    logic chk_rd;
    logic [3:0] ra, rb;
    logic [2:0] tw;
    logic chk_wr;
    logic [3:0] wa, wb;
    logic wbank;
  } vec_t;

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] tw;
    logic bank;
    logic [1:0] stage;
  } rd_exp_t;

  typedef struct {
    logic [3:0] a, b;
    logic bank;
    logic [1:0] stage;
    int due;
  } wr_exp_t;

  int      tests = 0;
  int      fails = 0;
  int      edge_n = 0;
  bit      sb_on = 0;
  vec_t    vecs[$];
  rd_exp_t rdq[$];
  wr_exp_t wrq[$];
  int      wcount [LOG2N][N];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic vec_t mk(int c, int rd, int wr, int bsy, int dn, int stg,
                              int rbk, int cr, int ra, int rb, int tw,
                              int cw, int wa, int wb, int wbk);
    vec_t v;
    v.cyc = c;          v.rd_en = 1'(rd);  v.wr_en = 1'(wr);
    v.busy = 1'(bsy);   v.done = 1'(dn);   v.stage = 2'(stg);
    v.rd_bank = 1'(rbk); v.chk_rd = 1'(cr); v.ra = 4'(ra);
    v.rb = 4'(rb);      v.tw = 3'(tw);     v.chk_wr = 1'(cw);
    v.wa = 4'(wa);      v.wb = 4'(wb);     v.wbank = 1'(wbk);
    return v;
  endfunction

  // Expected issue order for a full transform, built group by group.
  task automatic sb_load();
    rd_exp_t e;
    rdq.delete();
    wrq.delete();
    foreach (wcount[s, a]) wcount[s][a] = 0;
    for (int s = 0; s < LOG2N; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          e.a     = 4'(g * 2 * span + p);
          e.b     = 4'(g * 2 * span + p + span);
          e.tw    = 3'(p * (N / (2 * span)));
          e.bank  = 1'(s % 2);
          e.stage = 2'(s);
          rdq.push_back(e);
        end
      end
    end
  endtask

  task automatic monitor();
    rd_exp_t e;
    wr_exp_t w;
    int      rd_stage;
    bit      have_rd;
    have_rd  = 0;
    rd_stage = 0;
    if (!sb_on) return;
    if (rd_en === 1'b1) begin
      if (rdq.size() == 0) check("unexpected_rd_en", rd_en, 0);
      else begin
        e = rdq.pop_front();
        check("rd_addr_a", rd_addr_a, e.a);
        check("rd_addr_b", rd_addr_b, e.b);
        check("tw_idx", tw_idx, e.tw);
        check("rd_bank", rd_bank, e.bank);
        check("rd_stage", stage, e.stage);
        rd_stage = e.stage;
        have_rd  = 1;
        w.a = e.a; w.b = e.b; w.bank = ~e.bank; w.stage = e.stage;
        w.due = edge_n + 3;
        wrq.push_back(w);
      end
    end
    if (wr_en === 1'b1) begin
      if (wrq.size() == 0) check("unexpected_wr_en", wr_en, 0);
      else begin
        w = wrq.pop_front();
        check("wr_cycle", edge_n, w.due);
        check("wr_addr_a", wr_addr_a, w.a);
        check("wr_addr_b", wr_addr_b, w.b);
        check("wr_bank", wr_bank, w.bank);
        wcount[w.stage][wr_addr_a]++;
        wcount[w.stage][wr_addr_b]++;
        if (have_rd && rd_stage == int'(w.stage))
          check("same_stage_bank_clash", rd_bank == wr_bank, 0);
      end
    end else if (wrq.size() > 0 && wrq[0].due <= edge_n) begin
      check("missing_wr_en", wr_en, 1);
      w = wrq.pop_front();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    monitor();
  endtask

  task automatic run_xform(input int stall_c, input int stall_n, input int restart_c,
                           input int rst_c, input int limit, input int expect_done,
                           input bit use_table);
    int t0, done_cyc;
    sb_load();
    sb_on    = 1;
    start    = 1'b1;
    stall    = (stall_c == 0 && stall_n > 0);
    rst      = 1'b0;
    t0       = edge_n + 1;
    done_cyc = -1;
    for (int c = 0; c < limit; c++) begin
      tick();
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (use_table) begin
        foreach (vecs[i]) begin
          if (vecs[i].cyc == c) begin
            check($sformatf("c%0d_rd_en", c), rd_en, vecs[i].rd_en);
            check($sformatf("c%0d_wr_en", c), wr_en, vecs[i].wr_en);
            check($sformatf("c%0d_busy", c), busy, vecs[i].busy);
            check($sformatf("c%0d_done", c), done, vecs[i].done);
            check($sformatf("c%0d_stage", c), stage, vecs[i].stage);
            check($sformatf("c%0d_rd_bank", c), rd_bank, vecs[i].rd_bank);
            if (vecs[i].chk_rd) begin
              check($sformatf("c%0d_ra", c), rd_addr_a, vecs[i].ra);
              check($sformatf("c%0d_rb", c), rd_addr_b, vecs[i].rb);
              check($sformatf("c%0d_tw", c), tw_idx, vecs[i].tw);
            end
            if (vecs[i].chk_wr) begin
              check($sformatf("c%0d_wa", c), wr_addr_a, vecs[i].wa);
              check($sformatf("c%0d_wb", c), wr_addr_b, vecs[i].wb);
              check($sformatf("c%0d_wbank", c), wr_bank, vecs[i].wbank);
            end
          end
        end
      end
      if (stall_n > 0 && c >= stall_c && c < stall_c + stall_n)
        check("stall_gap_rd_en", rd_en, 0);
      if (stall_n > 0 && c == stall_c + stall_n) begin
        check("stall_resume_rd_en", rd_en, 1);
        check("stall_resume_addr_a", rd_addr_a, 8);
      end
      if (restart_c >= 0 && c == restart_c + 1) begin
        check("restart_ignored_stage", stage, 1);
        check("restart_ignored_busy", busy, 1);
      end
      if (c == rst_c) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_stage", stage, 0);
        check("rst_rd_addr_a", rd_addr_a, 0);
        check("rst_wr_addr_a", wr_addr_a, 0);
        check("rst_wr_bank", wr_bank, 0);
      end
      start = (c + 1 == restart_c);
      stall = (c + 1 >= stall_c && c + 1 < stall_c + stall_n);
      rst   = (c + 1 == rst_c);
      if (c + 1 == rst_c) begin
        rdq.delete();
        wrq.delete();
      end
      if (done_cyc >= 0 && c > done_cyc) break;
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
    check("done_cycle", done_cyc, expect_done);
    if (rst_c < 0) begin
      check("result_bank", result_bank, 0);
      for (int s = 0; s < LOG2N; s++) begin
        int ones = 0;
        for (int a = 0; a < N; a++) if (wcount[s][a] == 1) ones++;
        check($sformatf("stage%0d_addr_once", s), ones, N);
      end
    end
    check("rdq_empty", rdq.size(), 0);
    check("wrq_empty", wrq.size(), 0);
    sb_on = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;

    //        cyc rd wr bsy dn stg rbk  chkrd ra rb tw  chkwr wa wb wbk
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0,  0,  0, 0));
    vecs.push_back(mk( 1, 1, 0, 1, 0, 0, 0,  1,  0,  1, 0,  0,  0,  0, 0));
    vecs.push_back(mk( 4, 1, 1, 1, 0, 0, 0,  1,  6,  7, 0,  1,  0,  1, 1));
    vecs.push_back(mk( 8, 1, 1, 1, 0, 0, 0,  1, 14, 15, 0,  1,  8,  9, 1));
    vecs.push_back(mk( 9, 0, 1, 1, 0, 0, 0,  0,  0,  0, 0,  1, 10, 11, 1));
    vecs.push_back(mk(11, 0, 1, 1, 0, 0, 0,  0,  0,  0, 0,  1, 14, 15, 1));
    vecs.push_back(mk(12, 1, 0, 1, 0, 1, 1,  1,  0,  2, 0,  0,  0,  0, 0));
    vecs.push_back(mk(15, 1, 1, 1, 0, 1, 1,  1,  5,  7, 4,  1,  0,  2, 0));
    vecs.push_back(mk(29, 1, 1, 1, 0, 2, 0,  1, 10, 14, 4,  1,  3,  7, 1));
    vecs.push_back(mk(39, 1, 1, 1, 0, 3, 1,  1,  5, 13, 5,  1,  2, 10, 0));
    vecs.push_back(mk(42, 0, 1, 1, 0, 3, 1,  0,  0,  0, 0,  1,  5, 13, 0));
    vecs.push_back(mk(44, 0, 1, 1, 0, 3, 1,  0,  0,  0, 0,  1,  7, 15, 0));
    vecs.push_back(mk(45, 0, 0, 0, 1, 3, 1,  0,  0,  0, 0,  0,  0,  0, 0));
    vecs.push_back(mk(46, 0, 0, 0, 0, 3, 1,  0,  0,  0, 0,  0,  0,  0, 0));

    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_stage", stage, 0);
    check("reset_rd_bank", rd_bank, 0);
    check("reset_result_bank", result_bank, 0);
    rst = 1'b0;
    tick();

    // stall_c, stall_n, restart_c, rst_c, limit, expect_done, use_table
    run_xform(-1, 0, -1, -1, 60, 45, 1);
    run_xform(-1, 0, 20, -1, 60, 45, 0);
    run_xform( 5, 3, -1, -1, 60, 48, 0);
    run_xform(-1, 0, -1,  6, 20, -1, 0);
    run_xform(-1, 0, -1, -1, 60, 45, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
